// File: rtl/mips_trace_pkg.sv
// Shared definitions for the mips write-back trace observer.
// Defines the entry layout (kind + pc + addr + data) and a helper that packs one entry.
package mips_trace_pkg;

  localparam logic TRACE_GRF = 1'b0;
  localparam logic TRACE_DM  = 1'b1;
  localparam int   TRACE_W   = 97;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  function automatic trace_entry_t packEntry(input logic        kind,
                                             input logic [31:0] pc,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
    trace_entry_t e;
    e.kind = kind;
    e.pc   = pc;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Entry storage for the trace FIFO: two write ports at adjacent slots, one async read port.
// Holds no pointer state; the owner guarantees the two write addresses never collide.
module trace_ring
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we0,
  input  logic [PW-1:0]      i_wa0,
  input  logic [TRACE_W-1:0] i_wd0,
  input  logic               i_we1,
  input  logic [PW-1:0]      i_wa1,
  input  logic [TRACE_W-1:0] i_wd1,
  input  logic [PW-1:0]      i_ra,
  output logic [TRACE_W-1:0] o_rd
);

  logic [TRACE_W-1:0] r_mem [DEPTH];

  // Storage is cleared on reset so the head fields read zero while empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_we0) r_mem[i_wa0] <= i_wd0;
      if (i_we1) r_mem[i_wa1] <= i_wd1;
    end
  end

  assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/mips_wb_trace.sv
// Passive observer of GRF writes (W) and DM stores (M): buffers them in program order
// and streams them out; events that do not fit are counted as drops, never stalled.
module mips_wb_trace
  import mips_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       grf_we,
  input  logic [31:0]                grf_pc,
  input  logic [4:0]                 grf_addr,
  input  logic [31:0]                grf_wd,
  input  logic                       dm_we,
  input  logic [31:0]                dm_pc,
  input  logic [31:0]                dm_addr,
  input  logic [31:0]                dm_wd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_kind,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_addr,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [LW-1:0]     r_level;
  logic              r_overflow;
  logic [DROP_W-1:0] r_dropCnt;

  logic              w_grfCand;
  logic              w_dmCand;
  logic              w_pop;
  logic [LW:0]       w_free;
  logic              w_grfAccept;
  logic              w_dmAccept;
  logic [1:0]        w_pushes;
  logic [1:0]        w_drops;
  logic [DROP_W:0]   w_dropSum;
  trace_entry_t      w_grfEntry;
  trace_entry_t      w_dmEntry;
  trace_entry_t      w_wd0;
  logic [TRACE_W-1:0] w_rd;
  trace_entry_t      w_head;

  assign w_grfCand = grf_we && (grf_addr != 5'd0);
  assign w_dmCand  = dm_we;
  assign w_pop     = (r_level != '0) && out_ready;

  // A same-cycle pop frees its slot, so space is judged after the pop.
  assign w_free      = (LW+1)'(DEPTH) - {1'b0, r_level} + (LW+1)'(w_pop);
  assign w_grfAccept = w_grfCand && (w_free >= (LW+1)'(1));
  assign w_dmAccept  = w_dmCand && (w_free >= (w_grfAccept ? (LW+1)'(2) : (LW+1)'(1)));

  assign w_pushes  = 2'(w_grfAccept) + 2'(w_dmAccept);
  assign w_drops   = 2'(w_grfCand && !w_grfAccept) + 2'(w_dmCand && !w_dmAccept);
  assign w_dropSum = {1'b0, r_dropCnt} + (DROP_W+1)'(w_drops);

  assign w_grfEntry = packEntry(TRACE_GRF, grf_pc, {27'd0, grf_addr}, grf_wd);
  assign w_dmEntry  = packEntry(TRACE_DM, dm_pc, dm_addr, dm_wd);
  assign w_wd0      = w_grfAccept ? w_grfEntry : w_dmEntry;

  trace_ring #(.DEPTH(DEPTH), .PW(PW)) u_ring (
    .clk   (clk),
    .reset (reset),
    .i_we0 (w_grfAccept || w_dmAccept),
    .i_wa0 (r_wp),
    .i_wd0 (w_wd0),
    .i_we1 (w_grfAccept && w_dmAccept),
    .i_wa1 (r_wp + PW'(1)),
    .i_wd1 (w_dmEntry),
    .i_ra  (r_rp),
    .o_rd  (w_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else begin
      r_wp    <= r_wp + PW'(w_pushes);
      r_rp    <= r_rp + PW'(w_pop);
      r_level <= r_level + LW'(w_pushes) - LW'(w_pop);
      if (w_drops != 2'd0) begin
        r_overflow <= 1'b1;
        r_dropCnt  <= w_dropSum[DROP_W] ? '1 : w_dropSum[DROP_W-1:0];
      end
    end
  end

  assign w_head    = trace_entry_t'(w_rd);
  assign out_valid = (r_level != '0);
  assign out_kind  = w_head.kind;
  assign out_pc    = w_head.pc;
  assign out_addr  = w_head.addr;
  assign out_data  = w_head.data;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_mips_wb_trace.sv
// Self-checking bench for mips_wb_trace: directed test-plan sequences followed by
// randomized traffic, all compared against a queue-based model of the trace FIFO.
module tb_mips_wb_trace;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;
  localparam int LW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset;
  logic              grf_we;
  logic [31:0]       grf_pc;
  logic [4:0]        grf_addr;
  logic [31:0]       grf_wd;
  logic              dm_we;
  logic [31:0]       dm_pc;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wd;
  logic              out_valid;
  logic              out_ready;
  logic              out_kind;
  logic [31:0]       out_pc;
  logic [31:0]       out_addr;
  logic [31:0]       out_data;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  mips_wb_trace #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .grf_we    (grf_we),
    .grf_pc    (grf_pc),
    .grf_addr  (grf_addr),
    .grf_wd    (grf_wd),
    .dm_we     (dm_we),
    .dm_pc     (dm_pc),
    .dm_addr   (dm_addr),
    .dm_wd     (dm_wd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_pc    (out_pc),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t  modelQ[$];
  int   modelDrops;
  logic modelOvf;
  int   errorCount = 0;
  int   checkCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Model: pop the head, then offer GRF then DM to whatever room remains.
  task automatic modelPush(input ev_t e);
    if (modelQ.size() < DEPTH) begin
      modelQ.push_back(e);
    end else begin
      modelOvf = 1'b1;
      if (modelDrops < (1 << DROP_W) - 1) modelDrops++;
    end
  endtask

  task automatic modelStep(input bit gWe, input logic [4:0] gA, input logic [31:0] gPc,
                           input logic [31:0] gWd, input bit dWe, input logic [31:0] dPc,
                           input logic [31:0] dA, input logic [31:0] dWd, input bit rdy,
                           input bit rstN);
    ev_t e;
    if (!rstN) begin
      modelQ.delete();
      modelDrops = 0;
      modelOvf   = 1'b0;
    end else begin
      if (modelQ.size() != 0 && rdy) void'(modelQ.pop_front());
      if (gWe && gA != 5'd0) begin
        e.kind = 1'b0; e.pc = gPc; e.addr = {27'd0, gA}; e.data = gWd;
        modelPush(e);
      end
      if (dWe) begin
        e.kind = 1'b1; e.pc = dPc; e.addr = dA; e.data = dWd;
        modelPush(e);
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("valid", 32'(out_valid), 32'(modelQ.size() != 0));
    checkOutput("level", 32'(level), 32'(modelQ.size()));
    checkOutput("overflow", 32'(overflow), 32'(modelOvf));
    checkOutput("dropCnt", 32'(drop_cnt), 32'(modelDrops));
    if (modelQ.size() != 0) begin
      checkOutput("headKind", 32'(out_kind), 32'(modelQ[0].kind));
      checkOutput("headPc", out_pc, modelQ[0].pc);
      checkOutput("headAddr", out_addr, modelQ[0].addr);
      checkOutput("headData", out_data, modelQ[0].data);
    end else begin
      checkOutput("fieldsNoX", 32'($isunknown({out_kind, out_pc, out_addr, out_data})), 32'd0);
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare just after the edge.
  task automatic applyStimulus(input bit gWe, input logic [4:0] gA, input logic [31:0] gPc,
                               input logic [31:0] gWd, input bit dWe, input logic [31:0] dPc,
                               input logic [31:0] dA, input logic [31:0] dWd, input bit rdy,
                               input bit rstN);
    grf_we = gWe; grf_addr = gA; grf_pc = gPc; grf_wd = gWd;
    dm_we = dWe; dm_pc = dPc; dm_addr = dA; dm_wd = dWd;
    out_ready = rdy; reset = rstN;
    @(posedge clk);
    modelStep(gWe, gA, gPc, gWd, dWe, dPc, dA, dWd, rdy, rstN);
    #1;
    compareAll();
  endtask

  task automatic idleCycle(input bit rdy, input bit rstN);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy, rstN);
  endtask

  task automatic dualPush(input int n, input bit rdy);
    applyStimulus(1'b1, 5'(n % 31 + 1), 32'h4000 + 32'(n * 8), 32'h1000 + 32'(n), 1'b1,
                  32'h4004 + 32'(n * 8), 32'h8000 + 32'(n * 4), 32'h2000 + 32'(n), rdy, 1'b1);
  endtask

  initial begin
    modelDrops = 0;
    modelOvf   = 1'b0;

    idleCycle(1'b0, 1'b0);
    idleCycle(1'b0, 1'b0);
    idleCycle(1'b0, 1'b1);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstKind", 32'(out_kind), 32'd0);
    checkOutput("rstPc", out_pc, 32'd0);
    checkOutput("rstAddr", out_addr, 32'd0);
    checkOutput("rstData", out_data, 32'd0);

    applyStimulus(1'b1, 5'd8, 32'h3000, 32'h1234, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    checkOutput("singleValid", 32'(out_valid), 32'd1);
    checkOutput("singleAddr", out_addr, 32'h8);
    checkOutput("singleData", out_data, 32'h1234);
    idleCycle(1'b1, 1'b1);
    checkOutput("singleDrained", 32'(level), 32'd0);

    applyStimulus(1'b1, 5'd9, 32'h3004, 32'h5, 1'b1, 32'h3008, 32'h10, 32'hFF, 1'b0, 1'b1);
    checkOutput("dualLevel", 32'(level), 32'd2);
    checkOutput("dualFirstKind", 32'(out_kind), 32'd0);
    idleCycle(1'b1, 1'b1);
    checkOutput("dualSecondKind", 32'(out_kind), 32'd1);
    checkOutput("dualSecondAddr", out_addr, 32'h10);
    idleCycle(1'b1, 1'b1);

    applyStimulus(1'b1, 5'd0, 32'h300C, 32'hDEAD, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("zeroRegLevel", 32'(level), 32'd0);
    checkOutput("zeroRegOvf", 32'(overflow), 32'd0);

    for (int i = 0; i < DEPTH / 2; i++) dualPush(i, 1'b0);
    checkOutput("fullLevel", 32'(level), 32'(DEPTH));
    dualPush(10, 1'b0);
    checkOutput("fullDrop", 32'(drop_cnt), 32'd2);
    checkOutput("fullOvf", 32'(overflow), 32'd1);
    dualPush(11, 1'b1);
    checkOutput("fullPopDrop", 32'(drop_cnt), 32'd3);
    checkOutput("fullPopLevel", 32'(level), 32'(DEPTH));

    idleCycle(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) dualPush(20 + i, 1'b1);
    idleCycle(1'b1, 1'b0);
    idleCycle(1'b1, 1'b1);
    checkOutput("midResetLevel", 32'(level), 32'd0);

    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom, $urandom,
                    ($urandom_range(0, 99) < 50), $urandom, $urandom, $urandom,
                    ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) >= 2));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mips_wb_trace.md
# mips_wb_trace

Downstream observer of the `mips` pipeline core. It captures architectural write events each cycle: register-file writes retiring from W, and data-memory stores issued from M. It buffers them in program order in a small FIFO and presents them one at a time on a valid/ready stream. The bench or a comparison model drains that stream and diffs it against a golden trace. The block is passive: it never back-pressures or stalls the core, and it records losses instead.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 4.
- `DROP_W`, 16: width of the drop counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-low; all state clears on a rising `clk` edge while `reset`==0.
- `grf_we` in 1: GRF write event this cycle (W stage).
- `grf_pc` in 32: PC of the writing instruction.
- `grf_addr` in 5: destination register.
- `grf_wd` in 32: written value.
- `dm_we` in 1: DM store event this cycle (M stage).
- `dm_pc` in 32: PC of the storing instruction.
- `dm_addr` in 32: byte address.
- `dm_wd` in 32: stored word.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head.
- `out_kind` out 1: 0 = GRF, 1 = DM.
- `out_pc` out 32: PC field of head entry.
- `out_addr` out 32: address field of head entry; GRF address zero-extended.
- `out_data` out 32: data field of head entry.
- `level` out clog2(DEPTH+1): current occupancy.
- `overflow` out 1: sticky; set by any dropped event.
- `drop_cnt` out DROP_W: dropped-event count; saturates at all-ones.

## Operation
- Event qualification:
  - GRF candidate = `grf_we && grf_addr!=0`; writes to $0 are silently ignored and not counted as drops.
  - DM candidate = `dm_we`.
- Ordering within a cycle: the GRF candidate (older instruction, in W) is pushed before the DM candidate (younger, in M). Zero, one or two pushes per cycle.
- Pop: occurs when `out_valid && out_ready`; at most one per cycle.
- Space check: `free = DEPTH - level + pop`, so a pop frees its slot in the same cycle.
  - Candidates are accepted in order while `free` allows.
  - Each rejected candidate sets `overflow` and increments `drop_cnt` by one, saturating.
  - If only one slot is free and both candidates are present, GRF is kept and DM is dropped.
- Output fields are driven from the head entry; `out_valid = (level != 0)`. While `out_valid`==0 the output fields are don't-care, but they must not be X after reset. Clear the storage on reset.
- `level` update: next = level + pushes − pop, always within 0..DEPTH.
- Pointers: a write pointer and a read pointer, each clog2(DEPTH) bits, wrap modulo DEPTH. A dual push writes slots wp and wp+1 (mod DEPTH).
- Reset mid-operation: all entries are discarded; `level`, pointers, `overflow` and `drop_cnt` go to 0. Events presented in the reset cycle are ignored.

## Timing
- Reset values: `out_valid`=0, `out_kind`=0, `out_pc`/`out_addr`/`out_data`=0, `level`=0, `overflow`=0, `drop_cnt`=0.
- Push-to-visible latency is 1 cycle. An event sampled at edge t appears at the head at t+1 if the FIFO was empty; otherwise it appears in order behind the older entries.
- The head advances on the edge where `out_valid && out_ready`. The new head is visible immediately after that edge.
- Full FIFO with simultaneous pop and two candidates: exactly one candidate (GRF) is accepted and the other is dropped.
- `out_ready` may be held high permanently. The steady-state drain rate is then one entry per cycle, so sustained dual pushes grow `level` by one per cycle.
- No combinational path from inputs to `out_*`. `out_valid` depends on registered state only.

## Structure
- Package `mips_trace_pkg`:
  - Constants `TRACE_GRF`=1'b0 and `TRACE_DM`=1'b1.
  - `TRACE_W`=97: entry width (kind + pc + addr + data).
  - Entry-packing function.
- Sub-module `trace_ring`: DEPTH×TRACE_W storage with two write ports (slots wp, wp+1) and one asynchronous read port at rp. Pointer/level/drop logic stays in `mips_wb_trace`.

## Test plan
- Reset with `reset`=0 for 2 cycles, then events idle → all outputs 0 and `level`=0; no X on any output.
- Single GRF write pc=0x3000, $8←0x1234 with `out_ready`=1 → next cycle `out_valid`=1, kind 0, addr 0x8, data 0x1234; one cycle later `level`=0.
- Same-cycle GRF (pc 0x3004, $9←5) and DM store (pc 0x3008, addr 0x10, 0xFF), `out_ready`=0 → `level`=2; drain order is GRF first, then DM.
- `grf_we`=1 with `grf_addr`=0 → no entry, `level` unchanged, `overflow` stays 0.
- `out_ready`=0, fill to DEPTH=8, then a dual push with no pop → both dropped, `drop_cnt`=2, `overflow`=1. Then dual push with `out_ready`=1 → GRF accepted, DM dropped, `drop_cnt`=3.
- Continuous dual pushes for 12 cycles with `out_ready`=1 → pointers wrap without loss or reordering; the drained sequence matches pushes in order until the first overflow; `reset` pulse mid-stream empties the FIFO next cycle.
